// File: rtl/key_param_pkg.sv
// Shared types and constants for the key-driven parameter controller.
package key_param_pkg;

  localparam int unsigned CH_SEL_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } hold_state_e;

  // Counter width able to hold values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, debouncer, press pulse and hold/auto-repeat FSM.
module key_debounce
  import key_param_pkg::*;
#(
  parameter int unsigned DEB_CNT   = 200,
  parameter int unsigned LONG_CNT  = 1000,
  parameter int unsigned REP_CNT   = 250,
  parameter bit          REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic evt_o
);

  localparam int unsigned DbW = cnt_w(DEB_CNT);
  localparam int unsigned HdW = cnt_w((LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT);

  logic [1:0]     sync_q, sync_d;
  logic           deb_q, deb_d;
  logic [DbW-1:0] deb_cnt_q, deb_cnt_d;
  hold_state_e    state_q, state_d;
  logic [HdW-1:0] hold_cnt_q, hold_cnt_d;
  logic           evt_q, evt_d;
  logic           press;

  always_comb begin
    // Internal level convention: 1 = pressed.
    sync_d    = {sync_q[0], ~key_n_i};
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DbW'(DEB_CNT - 1)) begin
        deb_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    press = deb_d & ~deb_q;

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    evt_d      = 1'b0;
    if (!deb_d) begin
      state_d    = StIdle;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (press) begin
            state_d    = StHold;
            hold_cnt_d = '0;
            evt_d      = 1'b1;
          end
        end
        StHold: begin
          if (REPEAT_EN) begin
            if (hold_cnt_q == HdW'(LONG_CNT - 1)) begin
              state_d    = StRepeat;
              hold_cnt_d = '0;
              evt_d      = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        StRepeat: begin
          if (hold_cnt_q == HdW'(REP_CNT - 1)) begin
            hold_cnt_d = '0;
            evt_d      = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      evt_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/key_param_ctrl.sv
// Three-key parameter editor: select channel, step its value up/down with limits.
module key_param_ctrl
  import key_param_pkg::*;
#(
  parameter int unsigned         N_CH     = 5,
  parameter int unsigned         W        = 11,
  parameter int unsigned         DEB_CNT  = 200,
  parameter int unsigned         LONG_CNT = 1000,
  parameter int unsigned         REP_CNT  = 250,
  parameter logic [N_CH*W-1:0]   MIN_V    = '0,
  parameter logic [N_CH*W-1:0]   MAX_V    = '1,
  parameter logic [N_CH*W-1:0]   STEP_V   = {N_CH{W'(1)}},
  parameter logic [N_CH*W-1:0]   INIT_V   = '0,
  parameter logic [N_CH-1:0]     WRAP     = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_sel,
  input  logic                key_inc,
  input  logic                key_dec,
  output logic [N_CH*W-1:0]   param_bus,
  output logic [CH_SEL_W-1:0] ch_sel,
  output logic [W-1:0]        disp_data,
  output logic                upd
);

  logic ev_sel, ev_inc, ev_dec;

  key_debounce #(
    .DEB_CNT(DEB_CNT), .LONG_CNT(LONG_CNT), .REP_CNT(REP_CNT), .REPEAT_EN(1'b0)
  ) u_sel (.clk(clk), .reset(reset), .key_n_i(key_sel), .evt_o(ev_sel));

  key_debounce #(
    .DEB_CNT(DEB_CNT), .LONG_CNT(LONG_CNT), .REP_CNT(REP_CNT), .REPEAT_EN(1'b1)
  ) u_inc (.clk(clk), .reset(reset), .key_n_i(key_inc), .evt_o(ev_inc));

  key_debounce #(
    .DEB_CNT(DEB_CNT), .LONG_CNT(LONG_CNT), .REP_CNT(REP_CNT), .REPEAT_EN(1'b1)
  ) u_dec (.clk(clk), .reset(reset), .key_n_i(key_dec), .evt_o(ev_dec));

  logic [W-1:0]        val_q [N_CH];
  logic [W-1:0]        val_d [N_CH];
  logic [CH_SEL_W-1:0] ch_q, ch_d;
  logic                chg_q, chg_d;
  logic [W-1:0]        disp_q;
  logic                upd_q;

  logic [W-1:0] cur, cur_min, cur_max, cur_step, inc_v, dec_v, new_v;
  logic         cur_wrap;
  logic [W:0]   sum;

  always_comb begin
    cur      = '0;
    cur_min  = '0;
    cur_max  = '0;
    cur_step = '0;
    cur_wrap = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_SEL_W'(i)) begin
        cur      = val_q[i];
        cur_min  = MIN_V[i*W +: W];
        cur_max  = MAX_V[i*W +: W];
        cur_step = STEP_V[i*W +: W];
        cur_wrap = WRAP[i];
      end
    end

    // Extra bit keeps the overflow visible to the limit compare.
    sum   = {1'b0, cur} + {1'b0, cur_step};
    inc_v = (sum > {1'b0, cur_max}) ? (cur_wrap ? cur_min : cur_max) : sum[W-1:0];
    dec_v = ({1'b0, cur} < ({1'b0, cur_min} + {1'b0, cur_step})) ?
            (cur_wrap ? cur_max : cur_min) : (cur - cur_step);

    new_v = cur;
    ch_d  = ch_q;
    if (ev_sel) begin
      ch_d = (ch_q == CH_SEL_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
    end else if (ev_inc && !ev_dec) begin
      new_v = inc_v;
    end else if (ev_dec && !ev_inc) begin
      new_v = dec_v;
    end

    val_d = val_q;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_SEL_W'(i)) begin
        val_d[i] = new_v;
      end
    end

    // A saturated no-op leaves new_v == cur and so raises no update.
    chg_d = (ch_d != ch_q) || (new_v != cur);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        val_q[i] <= INIT_V[i*W +: W];
      end
      ch_q   <= '0;
      chg_q  <= 1'b0;
      disp_q <= INIT_V[W-1:0];
      upd_q  <= 1'b0;
    end else begin
      val_q  <= val_d;
      ch_q   <= ch_d;
      chg_q  <= chg_d;
      disp_q <= cur;
      upd_q  <= chg_q;
    end
  end

  always_comb begin
    param_bus = '0;
    for (int i = 0; i < N_CH; i++) begin
      param_bus[i*W +: W] = val_q[i];
    end
  end

  assign ch_sel    = ch_q;
  assign disp_data = disp_q;
  assign upd       = upd_q;

endmodule
